// File: rtl/fp_result_checker.sv
// fp_result_checker: in-order comparison of fp_unit responses against queued expected entries.
// Build option: define FP_CHECK_STRICT_NAN_EN to compare NaN results bit-exactly.
module fp_result_checker #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exp_valid,
    input  logic [31:0]      exp_result,
    input  logic [4:0]       exp_flags,
    input  logic             exp_nocanon,
    input  logic             exp_last,
    input  logic             dut_ready,
    input  logic [31:0]      dut_result,
    input  logic [4:0]       dut_flags,
    output logic [1:0]       state_o,
    output logic             mismatch_o,
    output logic             overflow_o,
    output logic             underflow_o,
    output logic [CNT_W-1:0] checked_o,
    output logic [31:0]      fail_ref_o,
    output logic [31:0]      fail_calc_o,
    output logic [31:0]      fail_rdiff_o,
    output logic [4:0]       fail_fdiff_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } state_t;

    state_t state, state_next;

    logic [38:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;

    logic        active, empty, full;
    logic        push_req, push_ok, pop_ok, ovf_ev, unf_ev, mism;
    logic [31:0] head_result, rdiff;
    logic [4:0]  head_flags, fdiff;
    logic        head_nocanon, head_last;

    // Head is read straight from storage, so a same-cycle push is never seen by a pop.
    assign {head_result, head_flags, head_nocanon, head_last} = mem[rd_ptr];

    assign active   = (state == IDLE) || (state == RUN);
    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign pop_ok   = active && dut_ready && !empty;
    assign unf_ev   = active && dut_ready && empty;
    assign push_req = active && exp_valid;
    assign push_ok  = push_req && (!full || pop_ok);
    assign ovf_ev   = push_req && full && !pop_ok;

`ifdef FP_CHECK_STRICT_NAN_EN
    logic unused_nocanon;
    assign unused_nocanon = head_nocanon;
    assign rdiff = head_result ^ dut_result;
`else
    // A canonical NaN from the unit only has to agree on exponent and quiet bit.
    assign rdiff = (!head_nocanon && dut_result == 32'h7FC0_0000)
                 ? {1'b0, head_result[30:22] ^ dut_result[30:22], 22'b0}
                 : head_result ^ dut_result;
`endif
    assign fdiff = head_flags ^ dut_flags;
    assign mism  = pop_ok && !head_last && ((rdiff != '0) || (fdiff != '0));

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (unf_ev || ovf_ev) state_next = FAIL;
                else if (exp_valid)   state_next = RUN;
            end
            RUN: begin
                if (unf_ev || ovf_ev)          state_next = FAIL;
                else if (pop_ok && head_last)  state_next = PASS;
                else if (mism)                 state_next = FAIL;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr] <= {exp_result, exp_flags, exp_nocanon, exp_last};
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            checked_o    <= '0;
            mismatch_o   <= 1'b0;
            overflow_o   <= 1'b0;
            underflow_o  <= 1'b0;
            fail_ref_o   <= '0;
            fail_calc_o  <= '0;
            fail_rdiff_o <= '0;
            fail_fdiff_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (pop_ok && !head_last && (checked_o != '1)) checked_o <= checked_o + 1'b1;
            if (ovf_ev) overflow_o  <= 1'b1;
            if (unf_ev) underflow_o <= 1'b1;
            mismatch_o <= mism;
            if (mism) begin
                fail_ref_o   <= head_result;
                fail_calc_o  <= dut_result;
                fail_rdiff_o <= rdiff;
                fail_fdiff_o <= fdiff;
            end
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_fp_result_checker.sv
// Bench for fp_result_checker: vector table, directed corner sequences and a queue-based random model.
module tb_fp_result_checker;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             exp_valid, exp_nocanon, exp_last, dut_ready;
    logic [31:0]      exp_result, dut_result;
    logic [4:0]       exp_flags, dut_flags;
    logic [1:0]       state_o;
    logic             mismatch_o, overflow_o, underflow_o;
    logic [CNT_W-1:0] checked_o;
    logic [31:0]      fail_ref_o, fail_calc_o, fail_rdiff_o;
    logic [4:0]       fail_fdiff_o;

    always #5 clock = ~clock;

    fp_result_checker #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .exp_valid(exp_valid), .exp_result(exp_result), .exp_flags(exp_flags),
        .exp_nocanon(exp_nocanon), .exp_last(exp_last),
        .dut_ready(dut_ready), .dut_result(dut_result), .dut_flags(dut_flags),
        .state_o(state_o), .mismatch_o(mismatch_o), .overflow_o(overflow_o),
        .underflow_o(underflow_o), .checked_o(checked_o),
        .fail_ref_o(fail_ref_o), .fail_calc_o(fail_calc_o),
        .fail_rdiff_o(fail_rdiff_o), .fail_fdiff_o(fail_fdiff_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic idle_inputs();
        exp_valid = 1'b0; exp_result = '0; exp_flags = '0; exp_nocanon = 1'b0; exp_last = 1'b0;
        dut_ready = 1'b0; dut_result = '0; dut_flags = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic set_push(input logic [31:0] r, input logic [4:0] f, input logic nc, input logic last);
        exp_valid = 1'b1; exp_result = r; exp_flags = f; exp_nocanon = nc; exp_last = last;
    endtask

    task automatic set_pop(input logic [31:0] c, input logic [4:0] f);
        dut_ready = 1'b1; dut_result = c; dut_flags = f;
    endtask

    // Expected result difference from the checking rule: a canonical NaN answer is
    // only held to the exponent field and quiet bit of the reference.
    function automatic logic [31:0] model_rdiff(input logic [31:0] r, input logic [31:0] c, input logic nc);
        logic [31:0] d;
        logic        relax;
        d     = r ^ c;
        relax = !nc && (c == 32'h7FC0_0000);
`ifdef FP_CHECK_STRICT_NAN_EN
        relax = 1'b0;
`endif
        return relax ? (d & 32'h7FC0_0000) : d;
    endfunction

    typedef struct {
        logic [31:0] r;
        logic [4:0]  rf;
        logic        nc;
        logic [31:0] c;
        logic [4:0]  cf;
        logic [31:0] rd;
        logic [4:0]  fd;
    } vec_t;

    typedef struct {
        logic [31:0] r;
        logic [4:0]  f;
        logic        nc;
        logic        last;
    } ent_t;

    vec_t        vecs [10];
    ent_t        q [$];
    ent_t        h, ne;
    logic [31:0] exp_rd, c;
    logic [4:0]  cf;
    logic        mis, rdy, psh, act0;
    int unsigned mst, mchecked;
    logic        mmis, movf, munf;
    logic [31:0] mref, mcalc, mrd;
    logic [4:0]  mfd;

    initial begin
        vecs[0] = '{32'h3F80_0000, 5'h00, 1'b0, 32'h3F80_0000, 5'h00, 32'h0000_0000, 5'h00};
        vecs[1] = '{32'h3F80_0000, 5'h00, 1'b0, 32'h3F80_0001, 5'h01, 32'h0000_0001, 5'h01};
        vecs[2] = '{32'h7FC0_0001, 5'h10, 1'b0, 32'h7FC0_0000, 5'h10, 32'h0000_0000, 5'h00};
        vecs[3] = '{32'h7FC0_0001, 5'h10, 1'b1, 32'h7FC0_0000, 5'h10, 32'h0000_0001, 5'h00};
        vecs[4] = '{32'hFFC0_0000, 5'h00, 1'b0, 32'h7FC0_0000, 5'h00, 32'h0000_0000, 5'h00};
        vecs[5] = '{32'h7F80_0000, 5'h00, 1'b0, 32'h7FC0_0000, 5'h00, 32'h0040_0000, 5'h00};
        vecs[6] = '{32'h7FC1_2345, 5'h00, 1'b0, 32'h7FC0_0000, 5'h00, 32'h0000_0000, 5'h00};
        vecs[7] = '{32'h0000_0000, 5'h00, 1'b0, 32'h0000_0000, 5'h1F, 32'h0000_0000, 5'h1F};
        vecs[8] = '{32'h4049_0FDB, 5'h01, 1'b0, 32'h4049_0FDA, 5'h01, 32'h0000_0001, 5'h00};
        vecs[9] = '{32'h3F80_0000, 5'h00, 1'b0, 32'h7FC0_0000, 5'h00, 32'h4040_0000, 5'h00};

        idle_inputs();
        do_reset();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_mismatch", 32'(mismatch_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_underflow", 32'(underflow_o), 32'd0);
        check("rst_checked", 32'(checked_o), 32'd0);
        check("rst_fail_ref", fail_ref_o, 32'd0);
        check("rst_fail_calc", fail_calc_o, 32'd0);
        check("rst_fail_rdiff", fail_rdiff_o, 32'd0);
        check("rst_fail_fdiff", 32'(fail_fdiff_o), 32'd0);

        for (int i = 0; i < 10; i++) begin
`ifdef FP_CHECK_STRICT_NAN_EN
            exp_rd = vecs[i].r ^ vecs[i].c;
`else
            exp_rd = vecs[i].rd;
`endif
            mis = (exp_rd != 32'd0) || (vecs[i].fd != 5'd0);
            do_reset();
            set_push(vecs[i].r, vecs[i].rf, vecs[i].nc, 1'b0);
            tick();
            idle_inputs();
            check("vec_run", 32'(state_o), 32'd1);
            tick();
            set_pop(vecs[i].c, vecs[i].cf);
            tick();
            idle_inputs();
            check("vec_state", 32'(state_o), mis ? 32'd3 : 32'd1);
            check("vec_mismatch", 32'(mismatch_o), 32'(mis));
            check("vec_checked", 32'(checked_o), 32'd1);
            check("vec_rdiff", fail_rdiff_o, mis ? exp_rd : 32'd0);
            check("vec_fdiff", 32'(fail_fdiff_o), mis ? 32'(vecs[i].fd) : 32'd0);
            check("vec_ref", fail_ref_o, mis ? vecs[i].r : 32'd0);
            check("vec_calc", fail_calc_o, mis ? vecs[i].c : 32'd0);
            tick();
            check("vec_pulse_end", 32'(mismatch_o), 32'd0);
            if (mis) begin
                set_push(32'h1111_1111, 5'h03, 1'b0, 1'b0);
                set_pop(32'h1234_5678, 5'h1F);
                tick();
                idle_inputs();
                check("vec_frozen_calc", fail_calc_o, vecs[i].c);
                check("vec_frozen_state", 32'(state_o), 32'd3);
                check("vec_frozen_unf", 32'(underflow_o), 32'd0);
                check("vec_frozen_checked", 32'(checked_o), 32'd1);
            end
        end

        // Two matching results then the terminator.
        do_reset();
        set_push(32'h3F80_0000, 5'h00, 1'b0, 1'b0); tick();
        set_push(32'h4000_0000, 5'h00, 1'b0, 1'b0); tick();
        set_push(32'h0000_0000, 5'h00, 1'b0, 1'b1); tick();
        idle_inputs();
        check("pass_run", 32'(state_o), 32'd1);
        tick(); tick();
        set_pop(32'h3F80_0000, 5'h00); tick();
        check("pass_chk1", 32'(checked_o), 32'd1);
        set_pop(32'h4000_0000, 5'h00); tick();
        check("pass_chk2", 32'(checked_o), 32'd2);
        check("pass_mis", 32'(mismatch_o), 32'd0);
        set_pop(32'hDEAD_BEEF, 5'h1F); tick();
        idle_inputs();
        check("pass_state", 32'(state_o), 32'd2);
        check("pass_checked", 32'(checked_o), 32'd2);
        check("pass_nomis", 32'(mismatch_o), 32'd0);
        set_pop(32'h0000_0001, 5'h01); tick();
        idle_inputs();
        check("pass_terminal", 32'(state_o), 32'd2);
        check("pass_no_unf", 32'(underflow_o), 32'd0);

        // Five pushes into a four-deep queue.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_push(32'hA000_0000 + 32'(k), 5'h00, 1'b0, 1'b0);
            tick();
        end
        check("ovf_before", 32'(overflow_o), 32'd0);
        check("ovf_before_state", 32'(state_o), 32'd1);
        set_push(32'hA000_0004, 5'h00, 1'b0, 1'b0);
        tick();
        idle_inputs();
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_state", 32'(state_o), 32'd3);
        check("ovf_no_capture", fail_ref_o, 32'd0);
        check("ovf_mis", 32'(mismatch_o), 32'd0);

        // Push and pop together while full, then one more push proves occupancy stayed at four.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_push(32'hB000_0000 + 32'(k), 5'h00, 1'b0, 1'b0);
            tick();
        end
        set_push(32'hB000_0004, 5'h00, 1'b0, 1'b0);
        set_pop(32'hB000_0000, 5'h00);
        tick();
        idle_inputs();
        check("full_pp_ovf", 32'(overflow_o), 32'd0);
        check("full_pp_state", 32'(state_o), 32'd1);
        check("full_pp_checked", 32'(checked_o), 32'd1);
        set_push(32'hB000_0005, 5'h00, 1'b0, 1'b0);
        tick();
        idle_inputs();
        check("full_pp_then_ovf", 32'(overflow_o), 32'd1);

        // Response with nothing queued.
        do_reset();
        set_pop(32'h3F80_0000, 5'h00);
        tick();
        idle_inputs();
        check("unf_flag", 32'(underflow_o), 32'd1);
        check("unf_state", 32'(state_o), 32'd3);
        check("unf_checked", 32'(checked_o), 32'd0);
        check("unf_calc", fail_calc_o, 32'd0);

        // Reset with entries still queued.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_push(32'hC000_0000 + 32'(k), 5'h00, 1'b0, 1'b0);
            tick();
        end
        idle_inputs();
        set_pop(32'hC000_0000, 5'h00);
        tick();
        idle_inputs();
        check("midrst_pre_checked", 32'(checked_o), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_state", 32'(state_o), 32'd0);
        check("midrst_checked", 32'(checked_o), 32'd0);
        set_pop(32'hC000_0001, 5'h00);
        tick();
        idle_inputs();
        check("midrst_unf", 32'(underflow_o), 32'd1);
        check("midrst_fail", 32'(state_o), 32'd3);

        // Counter saturation with a 4-bit counter.
        do_reset();
        set_push(32'h4080_0000, 5'h02, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 17; k++) begin
            set_push(32'h4080_0000, 5'h02, 1'b0, 1'b0);
            set_pop(32'h4080_0000, 5'h02);
            tick();
        end
        idle_inputs();
        check("sat_checked", 32'(checked_o), 32'hF);
        check("sat_state", 32'(state_o), 32'd1);

        // Randomised episodes against a queue model.
        for (int e = 0; e < 25; e++) begin
            do_reset();
            q.delete();
            mst = 0; mchecked = 0; mmis = 0; movf = 0; munf = 0;
            mref = '0; mcalc = '0; mrd = '0; mfd = '0;
            for (int cyc = 0; cyc < 60; cyc++) begin
                if (q.size() > 0) rdy = ($urandom_range(0, 99) < 55);
                else              rdy = ($urandom_range(0, 99) < 2);
                if (q.size() >= DEPTH && !rdy) psh = ($urandom_range(0, 99) < 4);
                else                           psh = ($urandom_range(0, 99) < 50);
                ne.r = $urandom();
                if ($urandom_range(0, 3) == 0) ne.r[30:22] = 9'h1FF;
                ne.f    = 5'($urandom_range(0, 31));
                ne.nc   = ($urandom_range(0, 99) < 25);
                ne.last = ($urandom_range(0, 99) < 3);
                c  = $urandom();
                cf = 5'($urandom_range(0, 31));
                if (q.size() > 0) begin
                    h = q[0];
                    case ($urandom_range(0, 9))
                        0:       begin c = 32'h7FC0_0000; cf = h.f; end
                        1:       begin c = h.r ^ (32'h1 << $urandom_range(0, 31)); cf = h.f; end
                        2:       begin c = h.r; cf = h.f ^ 5'($urandom_range(0, 1)); end
                        default: begin c = h.r; cf = h.f; end
                    endcase
                end
                idle_inputs();
                if (psh) set_push(ne.r, ne.f, ne.nc, ne.last);
                if (rdy) set_pop(c, cf);

                mmis = 1'b0;
                act0 = (mst < 2);
                if (act0) begin
                    if (rdy) begin
                        if (q.size() == 0) begin
                            munf = 1'b1; mst = 3;
                        end else begin
                            h = q.pop_front();
                            if (h.last) mst = 2;
                            else begin
                                if (mchecked < 15) mchecked++;
                                exp_rd = model_rdiff(h.r, c, h.nc);
                                if (exp_rd != 0 || (h.f ^ cf) != 0) begin
                                    mst = 3; mmis = 1'b1;
                                    mref = h.r; mcalc = c; mrd = exp_rd; mfd = h.f ^ cf;
                                end
                            end
                        end
                    end
                    if (psh) begin
                        if (q.size() == DEPTH) begin
                            movf = 1'b1; mst = 3;
                        end else begin
                            q.push_back(ne);
                            if (mst == 0) mst = 1;
                        end
                    end
                end

                tick();
                check("rnd_state", 32'(state_o), 32'(mst));
                check("rnd_checked", 32'(checked_o), 32'(mchecked));
                check("rnd_mismatch", 32'(mismatch_o), 32'(mmis));
                check("rnd_overflow", 32'(overflow_o), 32'(movf));
                check("rnd_underflow", 32'(underflow_o), 32'(munf));
                check("rnd_ref", fail_ref_o, mref);
                check("rnd_calc", fail_calc_o, mcalc);
                check("rnd_rdiff", fail_rdiff_o, mrd);
                check("rnd_fdiff", 32'(fail_fdiff_o), 32'(mfd));
            end
            idle_inputs();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
